rhd2000_spi_master: RTL and testbench

Synthesizable SPI master that drives one Intan RHD2000 headstage: it serializes 16-bit commands onto `nCs`/`sClk`/`mosi` and deserializes the 16-bit `miso` word returned in the same frame. It sits directly upstream of the RHD2000 chip and is fed by the acquisition sequencer over a valid/ready command port. Each response is tagged with the command it answers. The chip returns a command's result two frames after the command is sent.

---
 rtl/rhd2000_spi_master.sv | 182 ++++++++++++++++++
 tb/tb_rhd2000_spi_master.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rhd2000_spi_master.sv
// SPI master for one Intan RHD2000: shifts out 16-bit commands, shifts in the 16-bit reply,
// and tags each reply with the command sent two frames earlier, which is the command it answers.
module rhd2000_spi_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_HIGH = 8
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic [15:0] cmd,
    output logic        rspValid,
    output logic [15:0] rsp,
    output logic [15:0] rspCmd,
    output logic        rspCmdValid,
    output logic        busy,
    output logic        nCs,
    output logic        sClk,
    output logic        mosi,
    input  logic        miso
);
    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_HIGH, S_LOW, S_GAP} state_e;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_HIGH - 2);

    state_e      state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [3:0]  bit_idx_q, bit_idx_d;
    logic [15:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic [15:0] cur_cmd_q, cur_cmd_d;
    logic [15:0] hist0_q, hist0_d;
    logic [15:0] hist1_q, hist1_d;
    logic [1:0]  frames_q, frames_d;
    logic [15:0] rsp_q, rsp_d;
    logic [15:0] rsp_cmd_q, rsp_cmd_d;
    logic        rsp_cmd_valid_q, rsp_cmd_valid_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        ncs_q, ncs_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        div_end;

    assign div_end = (phase_q == DIV_LAST);

    always_comb begin
        state_d         = state_q;
        phase_d         = phase_q;
        bit_idx_d       = bit_idx_q;
        tx_d            = tx_q;
        rx_d            = rx_q;
        cur_cmd_d       = cur_cmd_q;
        hist0_d         = hist0_q;
        hist1_d         = hist1_q;
        frames_d        = frames_q;
        rsp_d           = rsp_q;
        rsp_cmd_d       = rsp_cmd_q;
        rsp_cmd_valid_d = rsp_cmd_valid_q;
        rsp_valid_d     = 1'b0;
        mosi_d          = mosi_q;

        case (state_q)
            S_IDLE: begin
                if (cmdValid && ready_q) begin
                    tx_d      = cmd;
                    cur_cmd_d = cmd;
                    bit_idx_d = 4'd15;
                    phase_d   = 8'd0;
                    mosi_d    = cmd[15];
                    state_d   = S_LEAD;
                end
            end
            S_LEAD: begin
                if (div_end) begin
                    phase_d = 8'd0;
                    rx_d    = {rx_q[14:0], miso};
                    state_d = S_HIGH;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            S_HIGH: begin
                // Zero-fill the shift so mosi idles low once bit 0 has gone out.
                if (div_end) begin
                    phase_d = 8'd0;
                    tx_d    = {tx_q[14:0], 1'b0};
                    mosi_d  = tx_q[14];
                    state_d = S_LOW;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            S_LOW: begin
                if (div_end) begin
                    phase_d = 8'd0;
                    if (bit_idx_q != 4'd0) begin
                        bit_idx_d = bit_idx_q - 4'd1;
                        rx_d      = {rx_q[14:0], miso};
                        state_d   = S_HIGH;
                    end else begin
                        state_d         = S_GAP;
                        rsp_valid_d     = 1'b1;
                        rsp_d           = rx_q;
                        rsp_cmd_d       = hist1_q;
                        hist1_d         = hist0_q;
                        hist0_d         = cur_cmd_q;
                        rsp_cmd_valid_d = (frames_q >= 2'd2);
                        if (frames_q != 2'd2) begin
                            frames_d = frames_q + 2'd1;
                        end
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            S_GAP: begin
                if (phase_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // SPI lines and handshake are registered images of the next state.
        ncs_d   = !(state_d == S_LEAD || state_d == S_HIGH || state_d == S_LOW);
        sclk_d  = (state_d == S_HIGH);
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q         <= S_IDLE;
            hist0_q         <= 16'd0;
            hist1_q         <= 16'd0;
            frames_q        <= 2'd0;
            rsp_q           <= 16'd0;
            rsp_cmd_q       <= 16'd0;
            rsp_cmd_valid_q <= 1'b0;
            rsp_valid_q     <= 1'b0;
            ready_q         <= 1'b0;
            busy_q          <= 1'b0;
            ncs_q           <= 1'b1;
            sclk_q          <= 1'b0;
            mosi_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            hist0_q         <= hist0_d;
            hist1_q         <= hist1_d;
            frames_q        <= frames_d;
            rsp_q           <= rsp_d;
            rsp_cmd_q       <= rsp_cmd_d;
            rsp_cmd_valid_q <= rsp_cmd_valid_d;
            rsp_valid_q     <= rsp_valid_d;
            ready_q         <= ready_d;
            busy_q          <= busy_d;
            ncs_q           <= ncs_d;
            sclk_q          <= sclk_d;
            mosi_q          <= mosi_d;
        end
        phase_q   <= phase_d;
        bit_idx_q <= bit_idx_d;
        tx_q      <= tx_d;
        rx_q      <= rx_d;
        cur_cmd_q <= cur_cmd_d;
    end

    assign cmdReady    = ready_q;
    assign busy        = busy_q;
    assign nCs         = ncs_q;
    assign sClk        = sclk_q;
    assign mosi        = mosi_q;
    assign rspValid    = rsp_valid_q;
    assign rsp         = rsp_q;
    assign rspCmd      = rsp_cmd_q;
    assign rspCmdValid = rsp_cmd_valid_q;
endmodule

// File: tb/tb_rhd2000_spi_master.sv
// Directed bench: two masters (default timing and CLK_DIV=CS_HIGH=2), each wired to a small
// RHD2000 model that answers reads of ROM 40..44 with "INTAN" and echoes writes two frames later.
module tb_rhd2000_spi_master;
    logic        clk = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        nreset [2];
    logic        cmd_valid [2];
    logic [15:0] cmd [2];
    logic [15:0] intan [5] = '{16'h0049, 16'h004E, 16'h0054, 16'h0041, 16'h004E};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int DIV = (g == 0) ? 4 : 2;
        localparam int CSH = (g == 0) ? 8 : 2;
        logic        cmd_ready, rsp_valid, rsp_cmd_valid, busy, ncs, sclk, mosi;
        logic        miso = 1'b0;
        logic [15:0] rsp, rsp_cmd;

        rhd2000_spi_master #(.CLK_DIV(DIV), .CS_HIGH(CSH)) u_dut (
            .clk(clk), .nReset(nreset[g]), .cmdValid(cmd_valid[g]), .cmdReady(cmd_ready),
            .cmd(cmd[g]), .rspValid(rsp_valid), .rsp(rsp), .rspCmd(rsp_cmd),
            .rspCmdValid(rsp_cmd_valid), .busy(busy), .nCs(ncs), .sClk(sclk),
            .mosi(mosi), .miso(miso)
        );

        // Chip model: result of a command is shifted out two frames later.
        logic        b_ncs = 1'b1, b_sclk = 1'b0;
        logic [15:0] out_word = 16'h0, pend = 16'h0, out_sr = 16'h0, rx_sr = 16'h0;
        int          nbits = 0;
        logic [7:0]  regs [64] = '{default: 8'h00};

        function automatic logic [7:0] rd(input logic [5:0] a);
            case (a)
                6'd40:   rd = 8'h49;
                6'd41:   rd = 8'h4E;
                6'd42:   rd = 8'h54;
                6'd43:   rd = 8'h41;
                6'd44:   rd = 8'h4E;
                default: rd = regs[a];
            endcase
        endfunction

        function automatic logic [15:0] reply(input logic [15:0] c);
            if (c[15:14] == 2'b11)      reply = {8'h00, rd(c[13:8])};
            else if (c[15:14] == 2'b10) reply = {8'hFF, c[7:0]};
            else                        reply = 16'h0000;
        endfunction

        always @(posedge clk) begin
            b_ncs  <= ncs;
            b_sclk <= sclk;
            if (b_ncs && !ncs) begin
                miso   <= out_word[15];
                out_sr <= {out_word[14:0], 1'b0};
                rx_sr  <= 16'h0;
                nbits  <= 0;
            end else if (!ncs && b_sclk && !sclk) begin
                miso   <= out_sr[15];
                out_sr <= {out_sr[14:0], 1'b0};
            end
            if (!ncs && !b_sclk && sclk) begin
                rx_sr <= {rx_sr[14:0], mosi};
                nbits <= nbits + 1;
            end
            if (!b_ncs && ncs && nbits == 16) begin
                out_word <= pend;
                pend     <= reply(rx_sr);
                if (rx_sr[15:14] == 2'b10 && rx_sr[13:8] < 6'd40) regs[rx_sr[13:8]] <= rx_sr[7:0];
            end
        end

        // Bus monitor
        logic        m_ncs = 1'b1, m_sclk = 1'b0;
        int          falls = 0, rises = 0, fall_cyc = 0, rise_cyc = 0;
        int          low_len = 0, high_len = 0, period = 0, rsp_n = 0;
        logic [15:0] mosi_word = 16'h0;
        logic [15:0] rsp_log [16];
        logic [15:0] cmd_log [16];
        logic        cv_log [16];
        logic        edge_ok [16];

        always @(negedge clk) begin
            m_ncs  <= ncs;
            m_sclk <= sclk;
            if (m_ncs && !ncs) begin
                falls     <= falls + 1;
                fall_cyc  <= cyc;
                high_len  <= cyc - rise_cyc;
                period    <= cyc - fall_cyc;
                rises     <= 0;
                mosi_word <= 16'h0;
            end else if (!ncs && !m_sclk && sclk) begin
                rises     <= rises + 1;
                mosi_word <= {mosi_word[14:0], mosi};
            end
            if (!m_ncs && ncs) begin
                low_len  <= cyc - fall_cyc;
                rise_cyc <= cyc;
            end
            if (rsp_valid && rsp_n < 16) begin
                rsp_log[rsp_n] <= rsp;
                cmd_log[rsp_n] <= rsp_cmd;
                cv_log[rsp_n]  <= rsp_cmd_valid;
                edge_ok[rsp_n] <= (!m_ncs && ncs);
                rsp_n          <= rsp_n + 1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rspn(input int g);
        return (g == 0) ? g_inst[0].rsp_n : g_inst[1].rsp_n;
    endfunction

    function automatic logic rdy(input int g);
        return (g == 0) ? g_inst[0].cmd_ready : g_inst[1].cmd_ready;
    endfunction

    task automatic send(input int g, input logic [15:0] c);
        int t;
        t = 0;
        cmd_valid[g] = 1'b1;
        cmd[g]       = c;
        while (!rdy(g) && t < 2000) begin
            tick();
            t++;
        end
        check("send_accept", 32'(t < 2000), 32'd1);
        tick();
    endtask

    task automatic wait_rsp(input int g, input int n);
        int t;
        t = 0;
        while (rspn(g) < n && t < 2000) begin
            tick();
            t++;
        end
        check("rsp_arrival", 32'(t < 2000), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        nreset[0] = 1'b0; nreset[1] = 1'b0;
        cmd_valid[0] = 1'b0; cmd_valid[1] = 1'b0;
        cmd[0] = 16'h0; cmd[1] = 16'h0;
        repeat (4) tick();

        // Reset values
        check("rst_ncs", 32'(g_inst[0].ncs), 32'd1);
        check("rst_sclk", 32'(g_inst[0].sclk), 32'd0);
        check("rst_mosi", 32'(g_inst[0].mosi), 32'd0);
        check("rst_ready", 32'(g_inst[0].cmd_ready), 32'd0);
        check("rst_rspvalid", 32'(g_inst[0].rsp_valid), 32'd0);
        check("rst_rsp", 32'(g_inst[0].rsp), 32'd0);
        check("rst_rspcmd", 32'(g_inst[0].rsp_cmd), 32'd0);
        check("rst_rspcmdvalid", 32'(g_inst[0].rsp_cmd_valid), 32'd0);
        check("rst_busy", 32'(g_inst[0].busy), 32'd0);

        nreset[0] = 1'b1;
        tick();
        check("ready_after_release", 32'(g_inst[0].cmd_ready), 32'd1);
        repeat (1000) tick();
        check("idle_no_frames", 32'(g_inst[0].falls), 32'd0);
        check("idle_ncs", 32'(g_inst[0].ncs), 32'd1);
        check("idle_no_rsp", 32'(g_inst[0].rsp_n), 32'd0);

        // Single frame
        send(0, 16'hE800);
        check("hs_busy", 32'(g_inst[0].busy), 32'd1);
        check("hs_ncs_low", 32'(g_inst[0].ncs), 32'd0);
        check("hs_ready_low", 32'(g_inst[0].cmd_ready), 32'd0);
        cmd_valid[0] = 1'b0;
        wait_rsp(0, 1);
        check("single_ncs_low_len", 32'(g_inst[0].low_len), 32'd132);
        check("single_sclk_rises", 32'(g_inst[0].rises), 32'd16);
        check("single_mosi_word", 32'(g_inst[0].mosi_word), 32'hE800);
        check("single_cv", 32'(g_inst[0].cv_log[0]), 32'd0);
        check("single_rsp_at_ncs_rise", 32'(g_inst[0].edge_ok[0]), 32'd1);

        // Back-to-back reads
        send(0, 16'hE800);
        send(0, 16'hE900);
        send(0, 16'hEA00);
        check("b2b_period", 32'(g_inst[0].period), 32'd140);
        check("b2b_ncs_high", 32'(g_inst[0].high_len), 32'd8);
        cmd_valid[0] = 1'b0;
        wait_rsp(0, 4);
        check("b2b_rsp", 32'(g_inst[0].rsp_log[3]), 32'h0049);
        check("b2b_rspcmd", 32'(g_inst[0].cmd_log[3]), 32'hE800);
        check("b2b_cv", 32'(g_inst[0].cv_log[3]), 32'd1);
        check("b2b_mosi_word", 32'(g_inst[0].mosi_word), 32'hEA00);

        // Write echo
        send(0, 16'h8305);
        send(0, 16'hE800);
        send(0, 16'hE800);
        cmd_valid[0] = 1'b0;
        wait_rsp(0, 7);
        check("wr_rsp", 32'(g_inst[0].rsp_log[6]), 32'hFF05);
        check("wr_rspcmd", 32'(g_inst[0].cmd_log[6]), 32'h8305);
        check("wr_cv", 32'(g_inst[0].cv_log[6]), 32'd1);
        check("wr_model_reg3", 32'(g_inst[0].regs[3]), 32'h05);

        // Reset during HIGH of bit 7 (ninth sClk rise)
        send(0, 16'hE900);
        cmd_valid[0] = 1'b0;
        t = 0;
        while (g_inst[0].rises < 9 && t < 500) begin
            tick();
            t++;
        end
        check("reach_bit7", 32'(t < 500), 32'd1);
        check("bit7_sclk_high", 32'(g_inst[0].sclk), 32'd1);
        nreset[0] = 1'b0;
        tick();
        check("abort_ncs", 32'(g_inst[0].ncs), 32'd1);
        check("abort_sclk", 32'(g_inst[0].sclk), 32'd0);
        check("abort_mosi", 32'(g_inst[0].mosi), 32'd0);
        check("abort_busy", 32'(g_inst[0].busy), 32'd0);
        check("abort_rspcmd", 32'(g_inst[0].rsp_cmd), 32'd0);
        nreset[0] = 1'b1;
        tick();
        check("abort_no_rsp", 32'(g_inst[0].rsp_n), 32'd7);
        send(0, 16'hE800);
        send(0, 16'hE800);
        send(0, 16'hE800);
        cmd_valid[0] = 1'b0;
        wait_rsp(0, 10);
        check("post_rst_cv0", 32'(g_inst[0].cv_log[7]), 32'd0);
        check("post_rst_cv1", 32'(g_inst[0].cv_log[8]), 32'd0);
        check("post_rst_cv2", 32'(g_inst[0].cv_log[9]), 32'd1);
        check("post_rst_rspcmd2", 32'(g_inst[0].cmd_log[9]), 32'hE800);
        check("post_rst_rsp2", 32'(g_inst[0].rsp_log[9]), 32'h0049);

        // CLK_DIV=2, CS_HIGH=2: continuous reads of ROM 40..44, then two flush reads
        nreset[1] = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) send(1, 16'hE800 + 16'(k << 8));
        send(1, 16'hE800);
        send(1, 16'hE800);
        check("fast_period", 32'(g_inst[1].period), 32'd68);
        check("fast_ncs_high", 32'(g_inst[1].high_len), 32'd2);
        check("fast_ncs_low", 32'(g_inst[1].low_len), 32'd66);
        cmd_valid[1] = 1'b0;
        wait_rsp(1, 7);
        for (int k = 0; k < 5; k++) check("fast_intan", 32'(g_inst[1].rsp_log[k + 2]), 32'(intan[k]));
        check("fast_rspcmd", 32'(g_inst[1].cmd_log[6]), 32'hEC00);
        check("fast_cv", 32'(g_inst[1].cv_log[2]), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
